// File: rtl/uart_alu_cmd_ctrl.sv
// uart_alu_cmd_ctrl: frames opcode + operand bytes from an RX FIFO, hands the
// complete command to an external combinational ALU in one step, and streams
// the result back LSB-first through a TX FIFO honouring its full flag.
// Invalid opcodes answer with a single all-ones byte; a stalled frame is
// dropped after an inter-byte timeout.
module uart_alu_cmd_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int OP_BYTES    = 2,
  parameter int OPCODE_BITS = 6,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_rx_empty,
  input  logic [DATA_BITS-1:0]              i_r_data,
  input  logic                              i_tx_full,
  input  logic [DATA_BITS*OP_BYTES-1:0]     i_alu_result,
  output logic                              o_rd_uart,
  output logic                              o_wr_uart,
  output logic [DATA_BITS-1:0]              o_w_data,
  output logic [DATA_BITS*OP_BYTES-1:0]     o_op_a,
  output logic [DATA_BITS*OP_BYTES-1:0]     o_op_b,
  output logic [OPCODE_BITS-1:0]            o_op_code,
  output logic                              o_busy,
  output logic                              o_err_timeout,
  output logic                              o_err_opcode,
  output logic [7:0]                        o_frame_cnt
);

  localparam int OPW = DATA_BITS * OP_BYTES;
  localparam int BW  = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC);

  localparam logic [BW-1:0]        LAST_BYTE = BW'(OP_BYTES - 1);
  localparam logic [TW-1:0]        TO_LAST   = TW'(TIMEOUT_CYC - 1);
  // Bits of an opcode byte that must be zero for the opcode to be legal.
  localparam logic [DATA_BITS-1:0] HI_MASK   = {DATA_BITS{1'b1}} << OPCODE_BITS;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, TX, ERR_TX} state_t;

  state_t                  state_q;
  logic [BW-1:0]           byte_cnt_q;
  logic [BW-1:0]           tx_idx_q;
  logic [TW-1:0]           to_cnt_q;
  logic [OPCODE_BITS-1:0]  sh_op_q;
  logic [OPW-1:0]          sh_a_q;
  logic [OPW-1:0]          sh_b_q;
  logic [OPW-1:0]          result_q;
  logic [OPCODE_BITS-1:0]  op_code_q;
  logic [OPW-1:0]          op_a_q;
  logic [OPW-1:0]          op_b_q;
  logic [DATA_BITS-1:0]    w_data_q;
  logic                    err_to_q;
  logic                    err_op_q;
  logic [7:0]              frame_cnt_q;

  logic                    rd_phase;
  logic                    rx_pop;
  logic                    tx_push;
  logic                    opcode_ok;
  logic [OPW-1:0]          sh_a_d;
  logic [OPW-1:0]          sh_b_d;
  logic [BW-1:0]           tx_idx_d;
  logic [DATA_BITS-1:0]    res_bytes [OP_BYTES];

  // Pop and push strobes are combinational so that the FIFO flags of the
  // current cycle are honoured; both are suppressed while reset is held.
  assign rd_phase  = (state_q == IDLE) || (state_q == RD_A) || (state_q == RD_B);
  assign rx_pop    = i_reset && rd_phase && !i_rx_empty;
  assign tx_push   = i_reset && ((state_q == TX) || (state_q == ERR_TX)) && !i_tx_full;
  assign opcode_ok = (i_r_data & HI_MASK) == '0;
  assign tx_idx_d  = (tx_idx_q == LAST_BYTE) ? '0 : tx_idx_q + 1'b1;

  // Shadow operands with the incoming byte merged in at the current byte slot,
  // and the result split into bytes for the TX stream.
  for (genvar gi = 0; gi < OP_BYTES; gi++) begin : g_bytes
    assign sh_a_d[gi*DATA_BITS +: DATA_BITS] =
      (byte_cnt_q == BW'(gi)) ? i_r_data : sh_a_q[gi*DATA_BITS +: DATA_BITS];
    assign sh_b_d[gi*DATA_BITS +: DATA_BITS] =
      (byte_cnt_q == BW'(gi)) ? i_r_data : sh_b_q[gi*DATA_BITS +: DATA_BITS];
    assign res_bytes[gi] = result_q[gi*DATA_BITS +: DATA_BITS];
  end

  // Frame FSM: byte assembly, timeout, atomic ALU load, result streaming.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      tx_idx_q    <= '0;
      to_cnt_q    <= '0;
      sh_op_q     <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      result_q    <= '0;
      op_code_q   <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      w_data_q    <= '0;
      err_to_q    <= 1'b0;
      err_op_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      err_to_q <= 1'b0;
      err_op_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_pop) begin
            if (opcode_ok) begin
              sh_op_q    <= i_r_data[OPCODE_BITS-1:0];
              byte_cnt_q <= '0;
              to_cnt_q   <= '0;
              state_q    <= RD_A;
            end else begin
              err_op_q <= 1'b1;
              w_data_q <= '1;
              state_q  <= ERR_TX;
            end
          end
        end
        RD_A, RD_B: begin
          if (rx_pop) begin
            to_cnt_q <= '0;
            if (state_q == RD_A) sh_a_q <= sh_a_d;
            else                 sh_b_q <= sh_b_d;
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q <= '0;
              if (state_q == RD_A) begin
                state_q <= RD_B;
              end else begin
                // All three ALU inputs change on this single edge.
                op_code_q <= sh_op_q;
                op_a_q    <= sh_a_q;
                op_b_q    <= sh_b_d;
                state_q   <= EXEC;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end else if (to_cnt_q == TO_LAST) begin
            err_to_q   <= 1'b1;
            to_cnt_q   <= '0;
            byte_cnt_q <= '0;
            state_q    <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        EXEC: begin
          // The first result byte is staged so it is on o_w_data when TX writes.
          result_q <= i_alu_result;
          w_data_q <= i_alu_result[DATA_BITS-1:0];
          tx_idx_q <= '0;
          state_q  <= TX;
        end
        TX: begin
          if (tx_push) begin
            if (tx_idx_q == LAST_BYTE) begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
              state_q     <= IDLE;
            end else begin
              tx_idx_q <= tx_idx_d;
              w_data_q <= res_bytes[tx_idx_d];
            end
          end
        end
        ERR_TX: begin
          if (tx_push) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rd_uart     = rx_pop;
  assign o_wr_uart     = tx_push;
  assign o_w_data      = w_data_q;
  assign o_op_a        = op_a_q;
  assign o_op_b        = op_b_q;
  assign o_op_code     = op_code_q;
  assign o_busy        = (state_q != IDLE);
  assign o_err_timeout = err_to_q;
  assign o_err_opcode  = err_op_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule
